// File: rtl/boot_rom_flash_loader_if.sv
// Bundle for the boot ROM flash loader: the start/busy/done handshake, the
// SPI flash pins, the boot-memory write port and the checksum output.
// The master modport is the loader side; the slave modport is the system side.
interface boot_rom_flash_loader_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        spi_cs_n;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;
  logic        mem_we;
  logic [13:0] mem_a;
  logic [7:0]  mem_din;
  logic [7:0]  checksum;

  modport master (
    input  start,
    input  spi_miso,
    output busy,
    output done,
    output spi_cs_n,
    output spi_sck,
    output spi_mosi,
    output mem_we,
    output mem_a,
    output mem_din,
    output checksum
  );

  modport slave (
    output start,
    output spi_miso,
    input  busy,
    input  done,
    input  spi_cs_n,
    input  spi_sck,
    input  spi_mosi,
    input  mem_we,
    input  mem_a,
    input  mem_din,
    input  checksum
  );
endinterface

// File: rtl/boot_rom_flash_loader.sv
// Boot ROM flash loader: copies LENGTH bytes from SPI flash (READ 0x03 at
// FLASH_BASE, SPI mode 0) into the boot memory write port at 0..LENGTH-1.
// Optional macro BOOT_LOADER_CHECKSUM_EN enables a running 8-bit byte sum on
// the checksum output; without it checksum is tied to zero.
module boot_rom_flash_loader #(
  parameter logic [23:0] FLASH_BASE = 24'h0B0000,
  parameter int          LENGTH     = 16384,
  parameter int          SCK_HALF   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  boot_rom_flash_loader_if.master     bus
);

  localparam int                DIV_W    = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCK_HALF - 1);
  localparam logic [14:0]       LEN_L    = 15'(LENGTH);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_FINISH} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               sck_q, sck_d;
  logic               cs_n_q, cs_n_d;
  logic [31:0]        sh_q, sh_d;
  logic [6:0]         rx_q, rx_d;
  logic [4:0]         bit_q, bit_d;
  logic [14:0]        idx_q, idx_d;
  logic               we_q, we_d;
  logic [13:0]        a_q, a_d;
  logic [7:0]         din_q, din_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Divider tick marks the end of an SCK phase; rise/fall name which edge it is.
  logic       running;
  logic       tick;
  logic       rise;
  logic       fall;
  logic [7:0] byte_w;

  assign running = (state_q == S_CMD) || (state_q == S_DATA);
  assign tick    = (div_q == DIV_LAST);
  assign rise    = running && tick && !sck_q;
  assign fall    = running && tick && sck_q;
  assign byte_w  = {rx_q, bus.spi_miso};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: command phase ends on the 32nd falling edge, data phase
  // ends on the falling edge after the last byte has been written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_CMD;
      S_CMD:    if (fall && (bit_q == 5'd31)) state_d = S_DATA;
      S_DATA:   if (fall && (idx_q == LEN_L)) state_d = S_FINISH;
      S_FINISH: if (cs_n_q) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: SPI divider, shifters, byte assembly, write strobe.
  always_comb begin
    div_d  = div_q;
    sck_d  = sck_q;
    cs_n_d = cs_n_q;
    sh_d   = sh_q;
    rx_d   = rx_q;
    bit_d  = bit_q;
    idx_d  = idx_q;
    we_d   = 1'b0;
    a_d    = a_q;
    din_d  = din_q;
    busy_d = busy_q;
    done_d = done_q;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        sck_d = 1'b0;
        if (bus.start) begin
          cs_n_d = 1'b0;
          busy_d = 1'b1;
          done_d = 1'b0;
          sh_d   = {8'h03, FLASH_BASE};
          bit_d  = '0;
          idx_d  = '0;
        end
      end
      S_CMD, S_DATA: begin
        if (tick) begin
          div_d = '0;
          sck_d = ~sck_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
        // MOSI is the shifter MSB; shifting zeros in leaves MOSI low after the command.
        if ((state_q == S_CMD) && fall) begin
          sh_d  = {sh_q[30:0], 1'b0};
          bit_d = (bit_q == 5'd31) ? 5'd0 : bit_q + 5'd1;
        end
        if ((state_q == S_DATA) && rise) begin
          rx_d = byte_w[6:0];
          if (bit_q == 5'd7) begin
            bit_d = '0;
            we_d  = 1'b1;
            din_d = byte_w;
            a_d   = idx_q[13:0];
            idx_d = idx_q + 15'd1;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
        if ((state_q == S_DATA) && fall && (idx_q == LEN_L)) div_d = '0;
      end
      S_FINISH: begin
        if (!cs_n_q) begin
          if (tick) begin
            div_d  = '0;
            cs_n_d = 1'b1;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
          div_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset aborts any transfer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      sck_q  <= 1'b0;
      cs_n_q <= 1'b1;
      sh_q   <= '0;
      rx_q   <= '0;
      bit_q  <= '0;
      idx_q  <= '0;
      we_q   <= 1'b0;
      a_q    <= '0;
      din_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sck_q  <= sck_d;
      cs_n_q <= cs_n_d;
      sh_q   <= sh_d;
      rx_q   <= rx_d;
      bit_q  <= bit_d;
      idx_q  <= idx_d;
      we_q   <= we_d;
      a_q    <= a_d;
      din_q  <= din_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  // Running sum updates on the same edge that registers the write strobe.
  always_comb begin
    csum_d = csum_q;
    if ((state_q == S_IDLE) && bus.start) csum_d = 8'h00;
    else if (we_d)                        csum_d = csum_q + din_d;
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= 8'h00;
    else        csum_q <= csum_d;
  end

  assign bus.checksum = csum_q;
`else
  assign bus.checksum = 8'h00;
`endif

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.spi_cs_n = cs_n_q;
  assign bus.spi_sck  = sck_q;
  assign bus.spi_mosi = sh_q[31];
  assign bus.mem_we   = we_q;
  assign bus.mem_a    = a_q;
  assign bus.mem_din  = din_q;

endmodule

// File: tb/tb_boot_rom_flash_loader.sv
// Bench for boot_rom_flash_loader: behavioural SPI flash model, expected
// writes queued per accepted start, monitor comparing every memory write.
module tb_boot_rom_flash_loader;

  localparam int          L    = 6;
  localparam int          H    = 2;
  localparam logic [23:0] BASE = 24'h0B0000;
  localparam int          CLK  = 10;

  logic clk;
  logic rst_n;
  logic miso_r;

  boot_rom_flash_loader_if bus();
  assign bus.spi_miso = miso_r;

  boot_rom_flash_loader #(.FLASH_BASE(BASE), .LENGTH(L), .SCK_HALF(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #(CLK/2) clk = ~clk;
  end

  typedef struct {
    logic [13:0] a;
    logic [7:0]  d;
    logic [7:0]  cs;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  img [L];
  logic [7:0]  exp_csum;
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          wr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Flash content as the flash sees it: image bytes at BASE.., 0xFF elsewhere.
  function automatic logic [7:0] flash_byte(input logic [23:0] addr);
    logic [23:0] off;
    off = addr - BASE;
    if (off < 24'(L)) return img[int'(off)];
    return 8'hFF;
  endfunction

  // ---------------- SPI flash model (mode 0) ----------------
  int          fcnt = 0;
  logic [31:0] fcmd = '0;
  logic        sck_prev = 1'b0;
  logic        cs_prev  = 1'b1;
  bit          have_rise = 1'b0;
  time         last_rise = 0;
  time         t_csfall  = 0;

  always @(bus.spi_cs_n or bus.spi_sck) begin
    int          j;
    logic [7:0]  b;
    if (cs_prev && !bus.spi_cs_n) t_csfall = $time;
    if (bus.spi_sck && !sck_prev) begin
      if (bus.spi_cs_n && cs_prev) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sck_idle: sck rose while cs_n=1 at t=%0t, expected no sck edge", $time);
      end else if (!bus.spi_cs_n) begin
        if (have_rise) chk("sck_period", 32'(($time - last_rise) / CLK), 32'(2*H));
        else           chk("first_sck_delay", 32'(($time - t_csfall) / CLK), 32'(H));
        have_rise = 1'b1;
        last_rise = $time;
        if (fcnt < 32) fcmd = {fcmd[30:0], bus.spi_mosi};
        fcnt++;
        if (fcnt == 32) chk("spi_cmd", fcmd, {8'h03, BASE});
      end
    end else if (!bus.spi_sck && sck_prev && !bus.spi_cs_n && (fcnt >= 32)) begin
      j = fcnt - 32;
      b = flash_byte(fcmd[23:0] + 24'(j / 8));
      miso_r = b[7 - (j % 8)];
    end
    if (bus.spi_cs_n) begin
      fcnt      = 0;
      have_rise = 1'b0;
      miso_r    = 1'b0;
    end
    sck_prev = bus.spi_sck;
    cs_prev  = bus.spi_cs_n;
  end

  // ---------------- Monitor / scoreboard ----------------
  exp_t e;
  time  last_we_t = 0;
  bit   have_we   = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (bus.mem_we) begin
      wr_seen++;
      chk("busy_during_write", {31'd0, bus.busy}, 32'd1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: mem_a=%0d din=0x%02h, expected no write", bus.mem_a, bus.mem_din);
      end else begin
        e = exp_q.pop_front();
        chk("mem_a", {18'd0, bus.mem_a}, {18'd0, e.a});
        chk("mem_din", {24'd0, bus.mem_din}, {24'd0, e.d});
        chk("checksum_running", {24'd0, bus.checksum}, {24'd0, e.cs});
      end
      if (have_we && (bus.mem_a != 14'd0))
        chk("we_interval", 32'(($time - last_we_t) / CLK), 32'(16*H));
      last_we_t = $time;
      have_we   = 1'b1;
    end
  end

  // ---------------- Reference model: expected writes of one copy ----------------
  task automatic push_copy();
    logic [7:0] s;
    exp_t       x;
    s = 8'h00;
    for (int k = 0; k < L; k++) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
      s = s + img[k];
`endif
      x.a  = 14'(k);
      x.d  = img[k];
      x.cs = s;
      exp_q.push_back(x);
    end
    exp_csum = s;
  endtask

  task automatic set_img(input int mode);
    for (int k = 0; k < L; k++) img[k] = 8'($urandom);
    if (mode == 0) for (int k = 0; k < L; k++) img[k] = 8'(8'h11 * (k + 1));
    if (mode == 1) begin
      img[0] = 8'h80;
      img[1] = 8'h90;
      img[2] = 8'h01;
    end
  endtask

  // Accepted start pulse; optionally releases reset in the same cycle.
  task automatic start_copy(input bit release_rst, output time t_s);
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    bus.start = 1'b1;
    push_copy();
    t_s = $time + CLK/2;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    chk("done_after_start", {31'd0, bus.done}, 32'd0);
    chk("cs_n_after_start", {31'd0, bus.spi_cs_n}, 32'd0);
    chk("checksum_cleared", {24'd0, bus.checksum}, 32'd0);
  endtask

  task automatic wait_writes(input int target);
    int i;
    for (i = 0; i < 2000 && wr_seen < target; i++) @(negedge clk);
    if (wr_seen < target) begin
      n_cmp++;
      n_fail++;
      $display("FAIL write_timeout: got %0d writes, expected %0d", wr_seen, target);
    end
  endtask

  task automatic finish_copy(input time t_s);
    bit  ok;
    time t_d;
    int  cyc;
    int  lo;
    ok  = 1'b0;
    t_d = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        ok  = 1'b1;
        t_d = $time - 1;
        break;
      end
    end
    chk("done_reached", {31'd0, ok}, 32'd1);
    if (ok) begin
      cyc = int'((t_d - t_s) / CLK);
      lo  = (32 + 8*L) * 2 * H;
      n_cmp++;
      if (cyc < lo || cyc > lo + H + 4) begin
        n_fail++;
        $display("FAIL copy_time: got %0d cycles, expected %0d..%0d", cyc, lo, lo + H + 4);
      end
      chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
      chk("cs_n_at_done", {31'd0, bus.spi_cs_n}, 32'd1);
      chk("sck_at_done", {31'd0, bus.spi_sck}, 32'd0);
      chk("checksum_final", {24'd0, bus.checksum}, {24'd0, exp_csum});
      chk("all_writes_seen", 32'(exp_q.size()), 32'd0);
      repeat ($urandom_range(1, 6)) @(negedge clk);
      chk("done_held", {31'd0, bus.done}, 32'd1);
      chk("checksum_held", {24'd0, bus.checksum}, {24'd0, exp_csum});
    end
  endtask

  // ---------------- Stimulus ----------------
  initial begin
    time t_s;
    int  base;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    miso_r    = 1'b0;
    exp_csum  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'd0, bus.spi_cs_n}, 32'd1);
    chk("rst_sck", {31'd0, bus.spi_sck}, 32'd0);
    chk("rst_mosi", {31'd0, bus.spi_mosi}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_a", {18'd0, bus.mem_a}, 32'd0);
    chk("rst_mem_din", {24'd0, bus.mem_din}, 32'd0);
    chk("rst_checksum", {24'd0, bus.checksum}, 32'd0);

    // Directed image, start coincident with reset release.
    set_img(0);
    start_copy(1'b1, t_s);
    finish_copy(t_s);

    // Random image with a start pulse during the data phase (must be ignored).
    set_img(2);
    base = wr_seen;
    start_copy(1'b0, t_s);
    wait_writes(base + 1);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    finish_copy(t_s);

    // Checksum-style image, aborted by reset after the second byte.
    set_img(1);
    base = wr_seen;
    start_copy(1'b0, t_s);
    wait_writes(base + 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", {31'd0, bus.spi_cs_n}, 32'd1);
    chk("abort_sck", {31'd0, bus.spi_sck}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_mem_we", {31'd0, bus.mem_we}, 32'd0);
    repeat (3) @(negedge clk);
    base = wr_seen;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("no_write_after_abort", 32'(wr_seen), 32'(base));
    start_copy(1'b0, t_s);
    finish_copy(t_s);

    // Random re-flash runs.
    for (int r = 0; r < 4; r++) begin
      set_img(2);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      start_copy(1'b0, t_s);
      finish_copy(t_s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule
